hams_syncfifo_pro: RTL and testbench

HAMS_SYNCFIFO_PRO -- requirements
Module: hams_syncfifo_pro

---
 rtl/hams_syncfifo_pro_pkg.sv | 14 +
 rtl/hams_syncfifo_pro_if.sv | 34 +++
 rtl/hams_syncfifo_pro_mem.sv | 26 ++
 rtl/hams_syncfifo_pro.sv | 136 +++++++++++++
 tb/tb_hams_syncfifo_pro.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/hams_syncfifo_pro_pkg.sv
// Shared types and elaboration helpers for the hams synchronous FIFO.
package hams_fifo_pkg;

    typedef enum logic {
        FIFO_REG  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Pointer width for a 0..depth-1 index; a 2-entry FIFO still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hams_syncfifo_pro_if.sv
// Push/pop handshake, data and status bundle of the hams synchronous FIFO.
interface hams_syncfifo_pro_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic             err_clr;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, push_data, pop, err_clr,
        input  pop_data, pop_valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, push_data, pop, err_clr,
        output pop_data, pop_valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/hams_syncfifo_pro_mem.sv
// DEPTH x WIDTH storage with one write port and one asynchronous read port; contents are never reset.
module hams_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/hams_syncfifo_pro.sv
// Synchronous FIFO with FWFT or registered read, occupancy-derived flags and sticky error flags.
module hams_syncfifo_pro
    import hams_fifo_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int FWFT     = 1,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                clk,
    input  logic                rst,
    hams_syncfifo_pro_if.slave  bus
);

    localparam int         AW   = ptr_width(DEPTH);
    localparam int         CW   = $clog2(DEPTH + 1);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;

    if (DEPTH < 2) begin : g_bad_depth
        $error("hams_syncfifo_pro: DEPTH must be at least 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_bad_af
        $error("hams_syncfifo_pro: AF_LEVEL must not exceed DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_bad_ae
        $error("hams_syncfifo_pro: AE_LEVEL must be below DEPTH");
    end

    logic [AW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s, raddr_s;
    logic [CW-1:0]    count_r, count_nxt_s;
    logic             push_acc_s, pop_acc_s, ovf_evt_s, udf_evt_s, bypass_s;
    logic [WIDTH-1:0] rdata_s, pop_data_r, pop_data_nxt_s;
    logic             pop_valid_r, pop_valid_nxt_s;
    logic             empty_r, full_r, almost_full_r, almost_empty_r;
    logic             overflow_r, underflow_r;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
    endfunction

    // Accept decisions, error events, pointer and occupancy next-state
    always_comb begin
        pop_acc_s    = bus.pop && !empty_r;
        push_acc_s   = bus.push && (!full_r || pop_acc_s);
        ovf_evt_s    = bus.push && !push_acc_s;
        udf_evt_s    = bus.pop && empty_r;
        wr_ptr_nxt_s = push_acc_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        rd_ptr_nxt_s = pop_acc_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        case ({push_acc_s, pop_acc_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FWFT prefetches the post-edge head so pop_data can stay a register.
    assign raddr_s  = (MODE == FIFO_FWFT) ? rd_ptr_nxt_s : rd_ptr_r;
    assign bypass_s = push_acc_s && (wr_ptr_r == rd_ptr_nxt_s);

    // Read-side next state for both read modes
    always_comb begin
        pop_data_nxt_s  = pop_data_r;
        pop_valid_nxt_s = 1'b0;
        if (MODE == FIFO_FWFT) begin
            pop_valid_nxt_s = (count_nxt_s != CW'(0));
            if (!pop_valid_nxt_s) begin
                pop_data_nxt_s = {WIDTH{1'b0}};
            end else if (bypass_s) begin
                pop_data_nxt_s = bus.push_data;
            end else begin
                pop_data_nxt_s = rdata_s;
            end
        end else begin
            pop_valid_nxt_s = pop_acc_s;
            if (pop_acc_s) begin
                pop_data_nxt_s = rdata_s;
            end else begin
                pop_data_nxt_s = pop_data_r;
            end
        end
    end

    // Control, status and error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r       <= {AW{1'b0}};
            rd_ptr_r       <= {AW{1'b0}};
            count_r        <= {CW{1'b0}};
            empty_r        <= 1'b1;
            full_r         <= 1'b0;
            almost_full_r  <= (AF_LEVEL == 0);
            almost_empty_r <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
            pop_valid_r    <= 1'b0;
            pop_data_r     <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_r       <= wr_ptr_nxt_s;
            rd_ptr_r       <= rd_ptr_nxt_s;
            count_r        <= count_nxt_s;
            empty_r        <= (count_nxt_s == CW'(0));
            full_r         <= (count_nxt_s == CW'(DEPTH));
            almost_full_r  <= (count_nxt_s >= CW'(AF_LEVEL));
            almost_empty_r <= (count_nxt_s <= CW'(AE_LEVEL));
            overflow_r     <= ovf_evt_s || (overflow_r && !bus.err_clr);
            underflow_r    <= udf_evt_s || (underflow_r && !bus.err_clr);
            pop_valid_r    <= pop_valid_nxt_s;
            pop_data_r     <= pop_data_nxt_s;
        end
    end

    hams_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc_s && !rst),
        .waddr (wr_ptr_r),
        .wdata (bus.push_data),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    assign bus.pop_data     = pop_data_r;
    assign bus.pop_valid    = pop_valid_r;
    assign bus.empty        = empty_r;
    assign bus.full         = full_r;
    assign bus.almost_full  = almost_full_r;
    assign bus.almost_empty = almost_empty_r;
    assign bus.count        = count_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_hams_syncfifo_pro.sv
// Bench for hams_syncfifo_pro: a FWFT instance (DEPTH=5) and a registered-read instance (DEPTH=7)
// share one stimulus stream; a sequence-number queue model predicts both every cycle.
module tb_hams_syncfifo_pro;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] push_data = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hams_syncfifo_pro_if #(.DEPTH(5), .WIDTH(8)) if_a ();
    hams_syncfifo_pro_if #(.DEPTH(7), .WIDTH(8)) if_b ();

    assign if_a.push = push;  assign if_a.pop = pop;
    assign if_a.push_data = push_data;  assign if_a.err_clr = err_clr;
    assign if_b.push = push;  assign if_b.pop = pop;
    assign if_b.push_data = push_data;  assign if_b.err_clr = err_clr;

    hams_syncfifo_pro #(.DEPTH(5), .WIDTH(8), .FWFT(1), .AF_LEVEL(4), .AE_LEVEL(1)) u_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    hams_syncfifo_pro #(.DEPTH(7), .WIDTH(8), .FWFT(0)) u_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    // Reference model: entries are numbered by write/read sequence numbers, occupancy = difference.
    logic [7:0] mdat [2][64];
    int         wseq [2];
    int         rseq [2];
    logic       e_ovf [2];
    logic       e_udf [2];
    logic       e_pv [2];
    logic [7:0] e_pd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int d, input int depth, input bit fwft);
        int n;
        bit pa, wa;
        n = wseq[d] - rseq[d];
        if (rst) begin
            wseq[d] = 0; rseq[d] = 0;
            e_ovf[d] = 1'b0; e_udf[d] = 1'b0; e_pv[d] = 1'b0; e_pd[d] = 8'h00;
        end else begin
            pa = pop && (n > 0);
            wa = push && ((n < depth) || pa);
            if (!fwft) begin
                e_pv[d] = pa;
                if (pa) e_pd[d] = mdat[d][rseq[d] % 64];
            end
            if (pa) rseq[d]++;
            if (wa) begin
                mdat[d][wseq[d] % 64] = push_data;
                wseq[d]++;
            end
            e_ovf[d] = (push && !wa) || (e_ovf[d] && !err_clr);
            e_udf[d] = (pop && (n == 0)) || (e_udf[d] && !err_clr);
        end
    endtask

    task automatic check_model(input int d, input int depth, input bit fwft, input int af, input int ae,
                               input logic [31:0] cnt, input logic e, input logic f, input logic a_f,
                               input logic a_e, input logic ov, input logic ud, input logic pv,
                               input logic [7:0] pd);
        int n;
        string p;
        n = wseq[d] - rseq[d];
        p = (d == 0) ? "A" : "B";
        chk({p, "_count"}, cnt, n);
        chk({p, "_empty"}, e, n == 0);
        chk({p, "_full"}, f, n == depth);
        chk({p, "_afull"}, a_f, n >= af);
        chk({p, "_aempty"}, a_e, n <= ae);
        chk({p, "_ovf"}, ov, e_ovf[d]);
        chk({p, "_udf"}, ud, e_udf[d]);
        if (fwft) begin
            chk({p, "_pvalid"}, pv, n > 0);
            chk({p, "_pdata"}, pd, (n > 0) ? mdat[d][rseq[d] % 64] : 8'h00);
        end else begin
            chk({p, "_pvalid"}, pv, e_pv[d]);
            chk({p, "_pdata"}, pd, e_pd[d]);
        end
    endtask

    // One clock: advance the model on the edge, then compare both instances 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step(0, 5, 1'b1);
        model_step(1, 7, 1'b0);
        #1;
        check_model(0, 5, 1'b1, 4, 1, if_a.count, if_a.empty, if_a.full, if_a.almost_full,
                    if_a.almost_empty, if_a.overflow, if_a.underflow, if_a.pop_valid, if_a.pop_data);
        check_model(1, 7, 1'b0, 5, 2, if_b.count, if_b.empty, if_b.full, if_b.almost_full,
                    if_b.almost_empty, if_b.overflow, if_b.underflow, if_b.pop_valid, if_b.pop_data);
    endtask

    task automatic drive(input logic r, input logic p, input logic o, input logic c, input logic [7:0] d);
        rst = r; push = p; pop = o; err_clr = c; push_data = d;
    endtask

    typedef struct {
        logic       r, p, o, c;
        logic [7:0] din;
        int         cnt;
        logic [7:0] pd;
        logic       f, e, ov, ud, af, ae;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, input logic p, input logic o, input logic c,
                                input logic [7:0] din, input int cnt, input logic [7:0] pd,
                                input logic f, input logic e, input logic ov, input logic ud,
                                input logic af, input logic ae);
        vec_t v;
        v.r = r; v.p = p; v.o = o; v.c = c; v.din = din; v.cnt = cnt; v.pd = pd;
        v.f = f; v.e = e; v.ov = ov; v.ud = ud; v.af = af; v.ae = ae;
        return v;
    endfunction

    initial begin
        int pr, pp;
        logic [7:0] exp_pd;
        foreach (wseq[i]) begin
            wseq[i] = 0; rseq[i] = 0; e_ovf[i] = 1'b0; e_udf[i] = 1'b0;
            e_pv[i] = 1'b0; e_pd[i] = 8'h00;
        end

        // Expected values for instance A (DEPTH=5, FWFT, AF_LEVEL=4, AE_LEVEL=1)
        //            r     p     o     c     din    cnt pd     f     e     ov    ud    af    ae
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 2, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h13, 3, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h14, 4, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h15, 5, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h66, 5, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3, 8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2, 8'h14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 2, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 3, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));

        foreach (vt[i]) begin
            drive(vt[i].r, vt[i].p, vt[i].o, vt[i].c, vt[i].din);
            tick();
            chk($sformatf("vec%0d_count", i), if_a.count, vt[i].cnt);
            chk($sformatf("vec%0d_pdata", i), if_a.pop_data, vt[i].pd);
            chk($sformatf("vec%0d_full", i), if_a.full, vt[i].f);
            chk($sformatf("vec%0d_empty", i), if_a.empty, vt[i].e);
            chk($sformatf("vec%0d_ovf", i), if_a.overflow, vt[i].ov);
            chk($sformatf("vec%0d_udf", i), if_a.underflow, vt[i].ud);
            chk($sformatf("vec%0d_afull", i), if_a.almost_full, vt[i].af);
            chk($sformatf("vec%0d_aempty", i), if_a.almost_empty, vt[i].ae);
        end

        // Full instance A under sustained push+pop: full holds and the pointers wrap twice.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h21 + 8'(k)); tick();
        end
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h70 + 8'(k)); tick();
            exp_pd = (k + 1 < 5) ? 8'h21 + 8'(k + 1) : 8'h70 + 8'(k - 4);
            chk($sformatf("wrap%0d_full", k), if_a.full, 1'b1);
            chk($sformatf("wrap%0d_count", k), if_a.count, 5);
            chk($sformatf("wrap%0d_pdata", k), if_a.pop_data, exp_pd);
        end

        // Registered read on instance B: one-cycle pop_valid pulse, pop_data held afterwards.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C); tick();
        chk("reg_pv_after_push", if_b.pop_valid, 1'b0);
        chk("reg_pd_after_push", if_b.pop_data, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); tick();
        chk("reg_pv_pulse", if_b.pop_valid, 1'b1);
        chk("reg_pd_pulse", if_b.pop_data, 8'h3C);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        chk("reg_pv_end", if_b.pop_valid, 1'b0);
        chk("reg_pd_hold", if_b.pop_data, 8'h3C);

        // Randomized phases with varying push/pop bias, occasional err_clr and reset.
        for (int c = 0; c < 1800; c++) begin
            case ((c / 300) % 6)
                0: begin pr = 70; pp = 30; end
                1: begin pr = 30; pp = 70; end
                2: begin pr = 50; pp = 50; end
                3: begin pr = 90; pp = 90; end
                4: begin pr = 95; pp = 5;  end
                default: begin pr = 5; pp = 95; end
            endcase
            drive($urandom_range(0, 249) == 0, $urandom_range(0, 99) < pr, $urandom_range(0, 99) < pp,
                  $urandom_range(0, 19) == 0, 8'($urandom));
            tick();
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
